uart_tx_queue: RTL

- Byte queue and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the CPU/bus side in single-cycle writes and buffers them in a FIFO.
- Feeds the transmitter one byte at a time over its tx_write / tx_data / tx_finished handshake.
- Holds tx_data stable for the whole frame, so the transmitter never sees data change mid-frame.

---
 rtl/uart_pkg.sv | 5 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_queue.sv | 75 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART width and transmit sequencer state encoding.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} seq_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/flags and combinational head read.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch sequencer feeding a UART transmitter,
// holding tx data stable from launch until the transmitter reports completion.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   uart_tx_write,
    output logic [DATA_W-1:0]      uart_tx_data,
    input  logic                   uart_tx_finished
);
    seq_state_e state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d, head;
    logic write_q, write_d, ovf_q, ovf_d, pop;
    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en && !flush),
        .pop   (pop),
        .flush (flush),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign busy          = state_q != IDLE;
    assign overflow      = ovf_q;
    assign uart_tx_write = write_q;
    assign uart_tx_data  = data_q;
    // A flushed write is discarded silently, so it never counts as a drop.
    assign ovf_d = (wr_en && full && !flush) || (ovf_q && !clr_overflow);
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        write_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && !flush) begin
                pop     = 1'b1;
                data_d  = head;
                write_d = 1'b1;
                state_d = LAUNCH;
            end
            LAUNCH: state_d = WAIT;
            WAIT: state_d = uart_tx_finished ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            write_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            write_q <= write_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
